// File: rtl/fw_layer_sequencer_if.sv
// Bus bundle between fw_layer_sequencer and its environment (layer RAMs,
// shared feed_forward_node, output buffer, layer control).
//   master : the sequencer (drives o_*, samples i_*)
//   slave  : the environment (drives i_*, samples o_*)
// Signals: i_start, o_busy, o_done, o_error (layer control);
//          o_rd_en, o_data_addr, o_weight_addr (RAM read side);
//          o_node_valid, i_node_result, i_node_valid (node side);
//          o_result, o_result_addr, o_result_valid (output buffer write).
interface fw_layer_sequencer_if #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned DATA_ADDR_WIDTH   = 6,
  parameter int unsigned WEIGHT_ADDR_WIDTH = 11,
  parameter int unsigned RESULT_ADDR_WIDTH = 5
) ();

  logic                         i_start;
  logic                         o_busy;
  logic                         o_done;
  logic                         o_error;
  logic                         o_rd_en;
  logic [DATA_ADDR_WIDTH-1:0]   o_data_addr;
  logic [WEIGHT_ADDR_WIDTH-1:0] o_weight_addr;
  logic                         o_node_valid;
  logic [DATA_WIDTH-1:0]        i_node_result;
  logic                         i_node_valid;
  logic [DATA_WIDTH-1:0]        o_result;
  logic [RESULT_ADDR_WIDTH-1:0] o_result_addr;
  logic                         o_result_valid;

  modport master (
    input  i_start, i_node_result, i_node_valid,
    output o_busy, o_done, o_error, o_rd_en, o_data_addr, o_weight_addr,
           o_node_valid, o_result, o_result_addr, o_result_valid
  );

  modport slave (
    output i_start, i_node_result, i_node_valid,
    input  o_busy, o_done, o_error, o_rd_en, o_data_addr, o_weight_addr,
           o_node_valid, o_result, o_result_addr, o_result_valid
  );

endinterface

// File: rtl/fw_layer_sequencer.sv
// Layer sequencer: time-multiplexes one feed_forward_node over all output
// neurons of a layer. For each neuron j it issues N reads (data addr i,
// weight addr j*N+i via a running pointer), marks the returned words valid
// for the node one cycle later, waits for the node result and writes it to
// the output buffer at address j.
// Ports: clk, rst_n (async active-low), bus (fw_layer_sequencer_if.master).
// Optional build macro FW_SEQ_TIMEOUT_EN: adds a WAIT-state watchdog of
// TIMEOUT_CYCLES that flags o_error and ends the layer early.
module fw_layer_sequencer #(
  parameter int unsigned DATA_WIDTH            = 32,
  parameter int unsigned NUMBER_OF_INPUT_NODE  = 33,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE = 32,
  parameter int unsigned DATA_ADDR_WIDTH       = 6,
  parameter int unsigned WEIGHT_ADDR_WIDTH     = 11,
  parameter int unsigned RESULT_ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES        = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  fw_layer_sequencer_if.master bus
);

  localparam logic [DATA_ADDR_WIDTH-1:0]   LAST_I =
    DATA_ADDR_WIDTH'(NUMBER_OF_INPUT_NODE - 1);
  localparam logic [RESULT_ADDR_WIDTH-1:0] LAST_J =
    RESULT_ADDR_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

  // Elaboration-time sanity check of the configuration.
  if ((NUMBER_OF_INPUT_NODE < 1) || (NUMBER_OF_OUTPUT_NODE < 1) ||
      (TIMEOUT_CYCLES < 1) ||
      ((64'(1) << DATA_ADDR_WIDTH) < 64'(NUMBER_OF_INPUT_NODE)) ||
      ((64'(1) << RESULT_ADDR_WIDTH) < 64'(NUMBER_OF_OUTPUT_NODE)) ||
      ((64'(1) << WEIGHT_ADDR_WIDTH) <
       (64'(NUMBER_OF_INPUT_NODE) * 64'(NUMBER_OF_OUTPUT_NODE)))) begin : g_bad_cfg
    $error("fw_layer_sequencer: invalid parameter configuration");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [DATA_ADDR_WIDTH-1:0]   i_q, i_d;
  logic [WEIGHT_ADDR_WIDTH-1:0] w_q, w_d;
  logic [RESULT_ADDR_WIDTH-1:0] j_q, j_d;
  logic                         capture_c;
  logic                         start_ok_c;
  logic                         fault_c;

  logic                         busy_q;
  logic                         done_q;
  logic                         rd_en_q;
  logic                         node_valid_q;
  logic [DATA_WIDTH-1:0]        result_q;
  logic [RESULT_ADDR_WIDTH-1:0] result_addr_q;
  logic                         result_valid_q;
  logic                         error_q;

`ifdef FW_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] LAST_WD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;

  // Watchdog: counts WAIT cycles, restarts from zero on every WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_q != S_WAIT) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    w_d        = w_q;
    j_d        = j_q;
    capture_c  = 1'b0;
    start_ok_c = 1'b0;
    // A node result outside WAIT is a protocol fault; it is dropped.
    fault_c    = bus.i_node_valid && (state_q != S_WAIT);

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          start_ok_c = 1'b1;
          state_d    = S_ISSUE;
          i_d        = '0;
          w_d        = '0;
          j_d        = '0;
        end
      end
      S_ISSUE: begin
        if (i_q == LAST_I) begin
          state_d = S_WAIT;
        end else begin
          i_d = i_q + DATA_ADDR_WIDTH'(1);
          w_d = w_q + WEIGHT_ADDR_WIDTH'(1);
        end
      end
      S_WAIT: begin
        if (bus.i_node_valid) begin
          capture_c = 1'b1;
          if (j_q == LAST_J) begin
            state_d = S_DONE;
          end else begin
            // Weight pointer keeps running across neurons: j*N+i without a multiply.
            state_d = S_ISSUE;
            j_d     = j_q + RESULT_ADDR_WIDTH'(1);
            i_d     = '0;
            w_d     = w_q + WEIGHT_ADDR_WIDTH'(1);
          end
        end
`ifdef FW_SEQ_TIMEOUT_EN
        else if (wd_q == LAST_WD) begin
          fault_c = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counters and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q            <= '0;
      w_q            <= '0;
      j_q            <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      node_valid_q   <= 1'b0;
      result_q       <= '0;
      result_addr_q  <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      i_q            <= i_d;
      w_q            <= w_d;
      j_q            <= j_d;
      busy_q         <= (state_d != S_IDLE);
      done_q         <= (state_d == S_DONE);
      rd_en_q        <= (state_d == S_ISSUE);
      // RAM words come back one cycle after the read strobe.
      node_valid_q   <= rd_en_q;
      result_valid_q <= capture_c;
      if (capture_c) begin
        result_q      <= bus.i_node_result;
        result_addr_q <= j_q;
      end
      // Fault wins over the clear so a fault coinciding with a start is kept.
      if (fault_c) begin
        error_q <= 1'b1;
      end else if (start_ok_c) begin
        error_q <= 1'b0;
      end
    end
  end

  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_error        = error_q;
  assign bus.o_rd_en        = rd_en_q;
  assign bus.o_data_addr    = i_q;
  assign bus.o_weight_addr  = w_q;
  assign bus.o_node_valid   = node_valid_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_addr  = result_addr_q;
  assign bus.o_result_valid = result_valid_q;

endmodule

// File: tb/tb_fw_layer_sequencer.sv
// Self-checking bench for fw_layer_sequencer (N=3, M=2). A behavioural node
// model answers each neuron after a chosen latency; a monitor logs the DUT
// activity and each test compares it with expectations derived from the
// layer rules (address sequences, cycle positions, layer duration).
module tb_fw_layer_sequencer;

  localparam int unsigned DW  = 32;
  localparam int unsigned N   = 3;
  localparam int unsigned M   = 2;
  localparam int unsigned DAW = 6;
  localparam int unsigned WAW = 11;
  localparam int unsigned RAW = 5;
  localparam int unsigned TO  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fw_layer_sequencer_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(DAW),
                          .WEIGHT_ADDR_WIDTH(WAW), .RESULT_ADDR_WIDTH(RAW)) bus ();

  fw_layer_sequencer #(
    .DATA_WIDTH(DW), .NUMBER_OF_INPUT_NODE(N), .NUMBER_OF_OUTPUT_NODE(M),
    .DATA_ADDR_WIDTH(DAW), .WEIGHT_ADDR_WIDTH(WAW), .RESULT_ADDR_WIDTH(RAW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic          model_v, stray_v;
  logic [DW-1:0] model_d, stray_d;
  assign bus.i_node_valid  = model_v | stray_v;
  assign bus.i_node_result = stray_v ? stray_d : model_d;

  bit            node_en;
  int            lat_q[$];
  logic [DW-1:0] val_q[$];

  int            cur_lat[M];
  logic [DW-1:0] cur_val[M];
  int            start_cyc;

  // Monitor logs
  int            da_log[$], wa_log[$], rd_cyc[$], nv_cyc[$], ra_log[$];
  logic [DW-1:0] rv_log[$];
  int            done_cnt, done_cyc;

  // Reference expectations
  int            exp_da[$], exp_wa[$], exp_rd[$], exp_nv[$], exp_ra[$];
  logic [DW-1:0] exp_rv[$];
  int            exp_done_cyc;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: sample mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.o_rd_en) begin
        rd_cyc.push_back(cyc);
        da_log.push_back(int'(bus.o_data_addr));
        wa_log.push_back(int'(bus.o_weight_addr));
      end
      if (bus.o_node_valid) nv_cyc.push_back(cyc);
      if (bus.o_result_valid) begin
        ra_log.push_back(int'(bus.o_result_addr));
        rv_log.push_back(bus.o_result);
      end
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Node model: after N valid inputs, answer L cycles after the last one.
  initial begin
    int seen;
    int delay;
    seen = 0;
    delay = 0;
    model_v = 1'b0;
    model_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !node_en) begin
        seen = 0;
        delay = 0;
      end else if (bus.o_node_valid) begin
        seen++;
        if (seen == int'(N)) begin
          seen = 0;
          delay = 1;
          if (lat_q.size() > 0) delay = lat_q.pop_front();
        end
      end
      @(posedge clk);
      #1;
      model_v = 1'b0;
      if (delay > 0) begin
        delay--;
        if (delay == 0 && rst_n && node_en) begin
          model_v = 1'b1;
          model_d = '0;
          if (val_q.size() > 0) model_d = val_q.pop_front();
        end
      end
    end
  end

  task automatic clear_log();
    da_log.delete(); wa_log.delete(); rd_cyc.delete(); nv_cyc.delete();
    ra_log.delete(); rv_log.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // Run one layer; a, b: cycles to pulse i_start; c: cycle of a stray node result.
  task automatic run_layer(input int a, input int b, input int c, output bit ok);
    clear_log();
    lat_q.delete(); val_q.delete();
    for (int j = 0; j < int'(M); j++) begin
      lat_q.push_back(cur_lat[j]);
      val_q.push_back(cur_val[j]);
    end
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    start_cyc = cyc + 1;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      bus.i_start = (k == a) || (k == b);
      stray_v = (k == c);
      stray_d = $urandom;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.i_start = 1'b0;
    stray_v = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference model: what a layer with cur_lat/cur_val must produce.
  task automatic build_model();
    int t;
    int sum;
    exp_da.delete(); exp_wa.delete(); exp_rd.delete(); exp_nv.delete();
    exp_ra.delete(); exp_rv.delete();
    t = 0;
    sum = 0;
    for (int j = 0; j < int'(M); j++) begin
      for (int i = 0; i < int'(N); i++) begin
        exp_da.push_back(i);
        exp_wa.push_back(j * int'(N) + i);
        exp_rd.push_back(start_cyc + t + i);
        exp_nv.push_back(start_cyc + t + i + 1);
      end
      exp_ra.push_back(j);
      exp_rv.push_back(cur_val[j]);
      // N issue cycles, node latency, one capture cycle.
      t += int'(N) + cur_lat[j] + 1;
      sum += cur_lat[j];
    end
    exp_done_cyc = start_cyc + int'(M * N) + sum + 2;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.i_start = 1'b0;
    stray_v = 1'b0;
    stray_d = '0;
    node_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_node_valid, bus.o_result_valid, bus.o_error} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_node_valid, bus.o_result_valid, bus.o_error});
    end
    vectors++;
    if (bus.o_data_addr !== '0 || bus.o_weight_addr !== '0 || bus.o_result_addr !== '0 || bus.o_result !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got data=%0h weight=%0h raddr=%0h result=%0h expected all 0",
               bus.o_data_addr, bus.o_weight_addr, bus.o_result_addr, bus.o_result);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic_layer();
    bit ok;
    cur_lat[0] = 4; cur_lat[1] = 4;
    cur_val[0] = 32'h3F80_0000; cur_val[1] = 32'h4000_0000;
    run_layer(-1, -1, -1, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_done_timeout: got no o_done expected o_done within budget");
    end
    vectors++;
    if (wa_log.size() != 6 || da_log.size() != 6) begin
      miscompares++;
      $display("FAIL basic_issue_count: got %0d/%0d expected 6/6", da_log.size(), wa_log.size());
    end
    for (int k = 0; k < 6 && k < wa_log.size(); k++) begin
      vectors++;
      if (wa_log[k] !== k || da_log[k] !== k % 3) begin
        miscompares++;
        $display("FAIL basic_addr[%0d]: got data=%0d weight=%0d expected data=%0d weight=%0d",
                 k, da_log[k], wa_log[k], k % 3, k);
      end
    end
    vectors++;
    if (ra_log.size() != 2 || ra_log[0] !== 0 || ra_log[1] !== 1 ||
        rv_log[0] !== 32'h3F80_0000 || rv_log[1] !== 32'h4000_0000) begin
      miscompares++;
      $display("FAIL basic_results: got %0d writes expected 2 writes 0:3f800000 1:40000000", ra_log.size());
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
    vectors++;
    if (done_cyc - start_cyc !== 16) begin
      miscompares++;
      $display("FAIL basic_duration: got %0d expected 16", done_cyc - start_cyc);
    end
    vectors++;
    if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_end_state: got error=%b busy=%b expected 0 0", bus.o_error, bus.o_busy);
    end
  endtask

  task automatic test_alignment_random();
    bit ok;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < int'(M); j++) begin
        cur_lat[j] = int'($urandom_range(1, 6));
        cur_val[j] = $urandom;
      end
      run_layer(-1, -1, -1, ok);
      build_model();
      vectors++;
      if (ok !== 1'b1 || done_cnt !== 1 || done_cyc !== exp_done_cyc) begin
        miscompares++;
        $display("FAIL rand%0d_done: got ok=%0d count=%0d cycle=%0d expected 1 1 %0d",
                 r, ok, done_cnt, done_cyc, exp_done_cyc);
      end
      vectors++;
      if (da_log.size() != exp_da.size() || rd_cyc.size() != exp_rd.size() || nv_cyc.size() != exp_nv.size()) begin
        miscompares++;
        $display("FAIL rand%0d_counts: got rd=%0d nv=%0d expected %0d %0d",
                 r, rd_cyc.size(), nv_cyc.size(), exp_rd.size(), exp_nv.size());
      end
      for (int k = 0; k < exp_da.size() && k < da_log.size() && k < nv_cyc.size(); k++) begin
        vectors++;
        if (da_log[k] !== exp_da[k] || wa_log[k] !== exp_wa[k] ||
            rd_cyc[k] !== exp_rd[k] || nv_cyc[k] !== exp_nv[k]) begin
          miscompares++;
          $display("FAIL rand%0d_beat%0d: got d=%0d w=%0d rd@%0d nv@%0d expected d=%0d w=%0d rd@%0d nv@%0d",
                   r, k, da_log[k], wa_log[k], rd_cyc[k], nv_cyc[k],
                   exp_da[k], exp_wa[k], exp_rd[k], exp_nv[k]);
        end
      end
      vectors++;
      if (ra_log.size() != exp_ra.size()) begin
        miscompares++;
        $display("FAIL rand%0d_result_count: got %0d expected %0d", r, ra_log.size(), exp_ra.size());
      end
      for (int k = 0; k < exp_ra.size() && k < ra_log.size(); k++) begin
        vectors++;
        if (ra_log[k] !== exp_ra[k] || rv_log[k] !== exp_rv[k]) begin
          miscompares++;
          $display("FAIL rand%0d_result%0d: got %0d:%h expected %0d:%h",
                   r, k, ra_log[k], rv_log[k], exp_ra[k], exp_rv[k]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    cur_lat[0] = 4; cur_lat[1] = 4;
    cur_val[0] = $urandom; cur_val[1] = $urandom;
    // Cycle 1 is inside ISSUE, cycle 5 inside the first WAIT.
    run_layer(1, 5, -1, ok);
    vectors++;
    if (ok !== 1'b1 || done_cnt !== 1 || done_cyc - start_cyc !== 16) begin
      miscompares++;
      $display("FAIL busy_start_done: got ok=%0d count=%0d duration=%0d expected 1 1 16",
               ok, done_cnt, done_cyc - start_cyc);
    end
    vectors++;
    if (wa_log.size() != 6) begin
      miscompares++;
      $display("FAIL busy_start_issue_count: got %0d expected 6", wa_log.size());
    end
    for (int k = 0; k < 6 && k < wa_log.size(); k++) begin
      vectors++;
      if (wa_log[k] !== k || da_log[k] !== k % 3) begin
        miscompares++;
        $display("FAIL busy_start_addr[%0d]: got data=%0d weight=%0d expected data=%0d weight=%0d",
                 k, da_log[k], wa_log[k], k % 3, k);
      end
    end
    vectors++;
    if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start_end: got error=%b busy=%b expected 0 0", bus.o_error, bus.o_busy);
    end
  endtask

  task automatic test_stray_result();
    bit ok;
    cur_lat[0] = 3; cur_lat[1] = 5;
    cur_val[0] = $urandom; cur_val[1] = $urandom;
    run_layer(-1, -1, 1, ok);
    vectors++;
    if (bus.o_error !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_error_set: got %b expected 1", bus.o_error);
    end
    vectors++;
    if (ok !== 1'b1 || done_cnt !== 1 || ra_log.size() != 2) begin
      miscompares++;
      $display("FAIL stray_layer: got ok=%0d done=%0d writes=%0d expected 1 1 2", ok, done_cnt, ra_log.size());
    end
    vectors++;
    if (ra_log.size() == 2 && (rv_log[0] !== cur_val[0] || rv_log[1] !== cur_val[1] || ra_log[1] !== 1)) begin
      miscompares++;
      $display("FAIL stray_values: got %h %h expected %h %h", rv_log[0], rv_log[1], cur_val[0], cur_val[1]);
    end
    cur_lat[0] = 2; cur_lat[1] = 2;
    run_layer(-1, -1, -1, ok);
    vectors++;
    if (bus.o_error !== 1'b0 || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_error_clear: got error=%b ok=%0d expected 0 1", bus.o_error, ok);
    end
  endtask

  task automatic test_reset_mid_layer();
    bit ok;
    cur_lat[0] = 4; cur_lat[1] = 4;
    cur_val[0] = $urandom; cur_val[1] = $urandom;
    clear_log();
    lat_q.delete(); val_q.delete();
    for (int j = 0; j < int'(M); j++) begin
      lat_q.push_back(cur_lat[j]);
      val_q.push_back(cur_val[j]);
    end
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    // Neuron 1 WAIT spans cycles 11..15.
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_node_valid, bus.o_result_valid, bus.o_error} !== 6'b0) begin
      miscompares++;
      $display("FAIL midreset_flags: got %b expected 000000",
               {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_node_valid, bus.o_result_valid, bus.o_error});
    end
    vectors++;
    if (bus.o_data_addr !== '0 || bus.o_weight_addr !== '0 || bus.o_result !== '0 || bus.o_result_addr !== '0) begin
      miscompares++;
      $display("FAIL midreset_values: got data=%0h weight=%0h result=%0h raddr=%0h expected all 0",
               bus.o_data_addr, bus.o_weight_addr, bus.o_result, bus.o_result_addr);
    end
    vectors++;
    if (done_cnt !== 0 || ra_log.size() != 1) begin
      miscompares++;
      $display("FAIL midreset_partial: got done=%0d writes=%0d expected 0 1", done_cnt, ra_log.size());
    end
    repeat (2) @(posedge clk);
    lat_q.delete(); val_q.delete();
    #1 rst_n = 1'b1;
    cur_lat[0] = 2; cur_lat[1] = 3;
    run_layer(-1, -1, -1, ok);
    vectors++;
    if (ok !== 1'b1 || da_log.size() != 6 || da_log[0] !== 0 || wa_log[0] !== 0 || wa_log[5] !== 5) begin
      miscompares++;
      $display("FAIL midreset_restart: got ok=%0d beats=%0d expected 1 6 starting at address 0", ok, da_log.size());
    end
    vectors++;
    if (done_cnt !== 1 || done_cyc - start_cyc !== 13 || ra_log.size() != 2) begin
      miscompares++;
      $display("FAIL midreset_restart_done: got done=%0d duration=%0d writes=%0d expected 1 13 2",
               done_cnt, done_cyc - start_cyc, ra_log.size());
    end
  endtask

  task automatic test_watchdog();
    node_en = 1'b0;
    clear_log();
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
`ifdef FW_SEQ_TIMEOUT_EN
    for (int k = 0; k < 100 && done_cnt == 0; k++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cnt !== 1 || done_cyc - start_cyc !== int'(N + TO)) begin
      miscompares++;
      $display("FAIL watchdog_done: got count=%0d at %0d expected 1 at %0d",
               done_cnt, done_cyc - start_cyc, N + TO);
    end
    vectors++;
    if (bus.o_error !== 1'b1 || ra_log.size() != 0 || wa_log.size() != int'(N)) begin
      miscompares++;
      $display("FAIL watchdog_effects: got error=%b writes=%0d beats=%0d expected 1 0 %0d",
               bus.o_error, ra_log.size(), wa_log.size(), N);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL watchdog_idle: got busy=%b expected 0", bus.o_busy);
    end
`else
    repeat (60) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt !== 0 || bus.o_busy !== 1'b1 || bus.o_rd_en !== 1'b0 || bus.o_error !== 1'b0) begin
      miscompares++;
      $display("FAIL no_timeout_wait: got done=%0d busy=%b rd=%b error=%b expected 0 1 0 0",
               done_cnt, bus.o_busy, bus.o_rd_en, bus.o_error);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`endif
    node_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic_layer();
    test_alignment_random();
    test_start_while_busy();
    test_stray_result();
    test_reset_mid_layer();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
